// File: rtl/irq_ctl_pkg.sv
// rtl/irq_ctl_pkg.sv - register offsets and FSM state encodings for the interrupt controller
package irq_ctl_pkg;

    localparam logic [2:0] IRQ_ENABLE  = 3'd0;
    localparam logic [2:0] IRQ_PENDING = 3'd1;
    localparam logic [2:0] IRQ_MODE    = 3'd2;
    localparam logic [2:0] IRQ_SWSET   = 3'd3;
    localparam logic [2:0] IRQ_EOI     = 3'd4;
    localparam logic [2:0] IRQ_STATUS  = 3'd5;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_SVC  = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_ctl_prio_enc.sv
// rtl/irq_ctl_prio_enc.sv - lowest-set-index priority encoder (bit 0 wins)
module prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic [4:0]   idx,
    output logic         any
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = 5'(i);
        end
    end

    assign any = |req;

endmodule

// File: rtl/irq_ctl.sv
// rtl/irq_ctl.sv - latches, masks and prioritises NIRQ sources into one vectored core request
module irq_ctl
    import irq_ctl_pkg::*;
#(
    parameter int NIRQ = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq_i,
    input  logic            stb,
    output logic            ack,
    input  logic            we,
    input  logic [2:0]      addr,
    input  logic [31:0]     dtw,
    output logic [31:0]     dtr,
    output logic            cpu_irq,
    output logic [4:0]      cpu_vec,
    input  logic            cpu_iack
);

    logic [NIRQ-1:0] enable_q, enable_d;
    logic [NIRQ-1:0] mode_q,   mode_d;
    logic [NIRQ-1:0] pend_q,   pend_d;
    logic [NIRQ-1:0] irq_q,    irq_d;
    irq_state_e      state_q,  state_d;
    logic [4:0]      vec_q,    vec_d;

    logic            wr;
    logic [NIRQ-1:0] rise_w;
    logic [NIRQ-1:0] pend_view;
    logic [NIRQ-1:0] req;
    logic [NIRQ-1:0] iack_sel;
    logic [31:0]     req_ext;
    logic [4:0]      win;
    logic            any_req;
    logic            take_iack;
    logic            unused_dtw;

    prio_enc #(.N(NIRQ)) u_prio (
        .req (req),
        .idx (win),
        .any (any_req)
    );

    assign req_ext    = 32'(req);
    assign unused_dtw = ^dtw;

    always_comb begin
        wr        = stb & we;
        rise_w    = irq_i & ~irq_q & mode_q;
        // Level lines are never stored; their pending view is the live input.
        pend_view = (pend_q & mode_q) | (irq_i & ~mode_q);
        req       = pend_view & enable_q;
        for (int i = 0; i < NIRQ; i++) begin
            iack_sel[i] = (vec_q == 5'(i));
        end

        state_d   = state_q;
        vec_d     = vec_q;
        take_iack = 1'b0;
        case (state_q)
            IRQ_IDLE: begin
                if (any_req) begin
                    state_d = IRQ_REQ;
                    vec_d   = win;
                end
            end
            IRQ_REQ: begin
                if (cpu_iack) begin
                    state_d   = IRQ_SVC;
                    take_iack = 1'b1;
                end else if (!req_ext[vec_q]) begin
                    state_d = IRQ_IDLE;
                end
            end
            IRQ_SVC: begin
                if (wr && addr == IRQ_EOI) state_d = IRQ_IDLE;
            end
            default: state_d = IRQ_IDLE;
        endcase

        // Clears first, then sets, so a coincident new edge always re-pends.
        pend_d = pend_q;
        if (wr && addr == IRQ_PENDING) pend_d = pend_d & ~dtw[NIRQ-1:0];
        if (take_iack)                 pend_d = pend_d & ~iack_sel;
        if (wr && addr == IRQ_SWSET)   pend_d = pend_d | dtw[NIRQ-1:0];
        pend_d = (pend_d | rise_w) & mode_q;

        enable_d = (wr && addr == IRQ_ENABLE) ? dtw[NIRQ-1:0] : enable_q;
        mode_d   = (wr && addr == IRQ_MODE)   ? dtw[NIRQ-1:0] : mode_q;
        irq_d    = irq_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q <= '0;
            mode_q   <= '0;
            pend_q   <= '0;
            irq_q    <= '0;
            state_q  <= IRQ_IDLE;
            vec_q    <= '0;
        end else begin
            enable_q <= enable_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
            state_q  <= state_d;
            vec_q    <= vec_d;
        end
    end

    always_comb begin
        case (addr)
            IRQ_ENABLE:  dtr = 32'(enable_q);
            IRQ_PENDING: dtr = 32'(pend_view);
            IRQ_MODE:    dtr = 32'(mode_q);
            IRQ_STATUS:  dtr = {25'b0, state_q, vec_q};
            default:     dtr = 32'b0;
        endcase
    end

    assign ack     = 1'b1;
    assign cpu_irq = (state_q == IRQ_REQ);
    assign cpu_vec = vec_q;

endmodule
